sseg_share_arb: RTL and testbench

Arbiter and scan controller that shares the 4-digit seven-segment display between `N_REQ` independent requesters. Each requester presents a 32-bit frame of four pre-decoded segment patterns, for example from `hex_to_sseg` instances. The block grants the display to one owner at a time, enforces a minimum ownership time, and time-multiplexes the owner's digits onto `an`/`sseg`. It replaces a fixed single-source `disp_mux` at the top level when several units must drive the display.

---
 rtl/sseg_arb_pkg.sv | 44 ++++
 rtl/sseg_scan_timer.sv | 27 ++
 rtl/sseg_share_arb.sv | 147 ++++++++++++++
 tb/tb_sseg_share_arb.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sseg_arb_pkg.sv
// Shared types and helpers for the seven-segment display share arbiter:
// FSM state enum, blank patterns and the request pick functions.
package sseg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN    = 2'd1,
    SWITCH = 2'd2
  } arb_state_e;

  localparam logic [7:0] SSEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_BLANK   = 4'hF;

  // Round-robin pick: search starts at the index after 'last' and wraps,
  // so 'last' itself is only chosen when it is the sole requester.
  function automatic logic [3:0] rr_pick(input logic [3:0] req,
                                         input logic [1:0] last,
                                         input int         n);
    logic [3:0] g;
    logic [1:0] idx;
    g = '0;
    for (int i = n; i >= 1; i--) begin
      idx = 2'((int'(last) + i) % n);
      if (req[idx]) g = 4'b0001 << idx;
    end
    return g;
  endfunction

  // Fixed priority pick: lowest active index wins.
  function automatic logic [3:0] fixed_pick(input logic [3:0] req);
    return req & (~req + 4'd1);
  endfunction

  // One-hot to binary index (lowest set bit wins if several are set).
  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sseg_scan_timer.sv
// Free-running display scan counter; the top two bits select the digit.
module sseg_scan_timer
  import sseg_arb_pkg::*;
#(
  parameter int REFRESH_BITS = 18
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [1:0] digit
);

  logic [REFRESH_BITS-1:0] scan_cnt_q, scan_cnt_d;

  // Next count: wraps naturally, never cleared on ownership changes.
  always_comb begin
    scan_cnt_d = scan_cnt_q + REFRESH_BITS'(1);
  end

  // Scan counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) scan_cnt_q <= '0;
    else          scan_cnt_q <= scan_cnt_d;
  end

  assign digit = scan_cnt_q[REFRESH_BITS-1:REFRESH_BITS-2];

endmodule

// File: rtl/sseg_share_arb.sv
// Shares one 4-digit seven-segment display between N_REQ requesters.
// Grants one owner at a time with a minimum hold time, then scans the
// owner's four digit patterns onto an/sseg (registered one stage later).
// Build option: SSEG_ARB_FIXED_PRIO_EN selects lowest-index-wins
// arbitration instead of round-robin.
module sseg_share_arb
  import sseg_arb_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int HOLD_CYC     = 50_000_000,
  parameter int REFRESH_BITS = 18
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [32*N_REQ-1:0]  frame,
  output logic [N_REQ-1:0]     gnt,
  output logic                 busy,
  output logic [3:0]           an,
  output logic [7:0]           sseg
);

  localparam int HOLD_W = $clog2(HOLD_CYC + 1);

  arb_state_e        state_q, state_d;
  logic [1:0]        last_owner_q, last_owner_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]        an_q, an_d;
  logic [7:0]        sseg_q, sseg_d;

  logic [1:0]        digit;
  logic [3:0]        req4;
  logic [3:0]        pick;
  logic [1:0]        win_idx;
  logic              any_req;
  logic              others;
  logic              expired;
  logic [31:0]       owner_word;

  sseg_scan_timer #(
    .REFRESH_BITS(REFRESH_BITS)
  ) u_scan (
    .clk    (clk),
    .reset_n(reset_n),
    .digit  (digit)
  );

  // Request conditioning and winner selection for the next grant.
  always_comb begin
    req4              = '0;
    req4[N_REQ-1:0]   = req;
    any_req           = |req;
    others            = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i] && (last_owner_q != 2'(i))) others = 1'b1;
    end
`ifdef SSEG_ARB_FIXED_PRIO_EN
    pick = fixed_pick(req4);
`else
    pick = rr_pick(req4, last_owner_q, N_REQ);
`endif
    win_idx = onehot_idx(pick);
    expired = (hold_cnt_q == HOLD_W'(HOLD_CYC));
  end

  // Ownership FSM: next state, owner index and saturating hold counter.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    hold_cnt_d   = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d      = OWN;
          last_owner_d = win_idx;
          hold_cnt_d   = '0;
        end
      end
      OWN: begin
        if (!req4[last_owner_q] || (expired && others)) begin
          state_d = SWITCH;
        end else if (!expired) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      SWITCH: begin
        if (any_req) begin
          state_d      = OWN;
          last_owner_d = win_idx;
          hold_cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Display stage: pick the owner's byte for the current digit.
  always_comb begin
    owner_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (last_owner_q == 2'(i)) owner_word = frame[32*i +: 32];
    end
    an_d   = AN_BLANK;
    sseg_d = SSEG_BLANK;
    if (state_q == OWN) begin
      an_d = ~(4'b0001 << digit);
      case (digit)
        2'd0:    sseg_d = owner_word[7:0];
        2'd1:    sseg_d = owner_word[15:8];
        2'd2:    sseg_d = owner_word[23:16];
        default: sseg_d = owner_word[31:24];
      endcase
    end
  end

  // State, owner, hold counter and display registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_owner_q <= 2'(N_REQ - 1);
      hold_cnt_q   <= '0;
      an_q         <= AN_BLANK;
      sseg_q       <= SSEG_BLANK;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
      an_q         <= an_d;
      sseg_q       <= sseg_d;
    end
  end

  // Grant decode straight from the state/owner registers.
  always_comb begin
    gnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gnt[i] = (state_q == OWN) && (last_owner_q == 2'(i));
    end
  end

  assign busy = (state_q != IDLE);
  assign an   = an_q;
  assign sseg = sseg_q;

endmodule

// File: tb/tb_sseg_share_arb.sv
// Bench for sseg_share_arb: directed scenarios plus random requests,
// every cycle compared against a behavioural model of ownership and scan.
module tb_sseg_share_arb;

  localparam int N    = 2;
  localparam int HOLD = 8;
  localparam int RB   = 4;

  logic            clk;
  logic            reset_n;
  logic [N-1:0]    req;
  logic [32*N-1:0] frame;
  logic [N-1:0]    gnt;
  logic            busy;
  logic [3:0]      an;
  logic [7:0]      sseg;

  int errors = 0;
  int checks = 0;

  // model: mode 0 = no owner, 1 = owned, 2 = one-cycle handover gap
  int         m_mode, m_last, m_age, m_scan;
  logic [3:0] e_an;
  logic [7:0] e_sseg;

  sseg_share_arb #(
    .N_REQ(N), .HOLD_CYC(HOLD), .REFRESH_BITS(RB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .frame(frame),
    .gnt(gnt), .busy(busy), .an(an), .sseg(sseg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_last = N - 1; m_age = 0; m_scan = 0;
    e_an = 4'hF; e_sseg = 8'hFF;
  endtask

  function automatic int model_pick(input logic [N-1:0] r, input int last);
`ifdef SSEG_ARB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) if (r[k]) return k;
    if (last < 0) return -1;
`else
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
`endif
    return -1;
  endfunction

  task automatic model_step(input logic [N-1:0] r, input logic [32*N-1:0] f, input logic rn);
    int d, w;
    bit oth;
    if (!rn) begin
      model_reset();
      return;
    end
    d = (m_scan >> (RB - 2)) % 4;
    if (m_mode == 1) begin
      e_an   = ~(4'b0001 << d);
      e_sseg = f[32*m_last + 8*d +: 8];
    end else begin
      e_an = 4'hF; e_sseg = 8'hFF;
    end
    m_scan = (m_scan + 1) % (1 << RB);
    oth = 0;
    for (int k = 0; k < N; k++) if (r[k] && k != m_last) oth = 1;
    w = model_pick(r, m_last);
    if (m_mode == 1) begin
      if (!r[m_last] || (m_age == HOLD && oth)) m_mode = 2;
      else if (m_age < HOLD) m_age++;
    end else if (w >= 0) begin
      m_mode = 1; m_last = w; m_age = 0;
    end else begin
      m_mode = 0;
    end
  endtask

  task automatic check_all();
    chk("gnt",  32'(gnt),  (m_mode == 1) ? (32'd1 << m_last) : 32'd0);
    chk("busy", 32'(busy), 32'(m_mode != 0));
    chk("an",   32'(an),   32'(e_an));
    chk("sseg", 32'(sseg), 32'(e_sseg));
  endtask

  task automatic tick();
    logic [N-1:0]    r;
    logic [32*N-1:0] f;
    logic            rn;
    r = req; f = frame; rn = reset_n;
    @(posedge clk);
    model_step(r, f, rn);
    #1;
    check_all();
  endtask

  initial begin
    int cnt;
    int nxt;
    reset_n = 1'b0;
    req     = 2'b11;
    frame   = {32'h92B08899, 32'hC0F9A4B0};
    model_reset();

    // reset held with both requesting
    repeat (3) begin
      tick();
      chk("rst_gnt",  32'(gnt),  32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_an",   32'(an),   32'hF);
      chk("rst_sseg", 32'(sseg), 32'hFF);
    end

    // first grant after reset goes to index 0; digits scan B0,A4,F9,C0
    req = 2'b00;
    reset_n = 1'b1;
    repeat (2) tick();
    req = 2'b01;
    tick();
    chk("first_gnt", 32'(gnt), 32'h1);
    repeat (18) tick();

    // back to idle, then rotation once requester 1 joins
    req = 2'b00;
    repeat (3) tick();
    chk("idle_busy", 32'(busy), 32'h0);
    req = 2'b01;
    tick();
    cnt = 0;
    while (gnt == 2'b01 && cnt < 40) begin
      cnt++;
      if (cnt == 2) req = 2'b11;
      tick();
    end
    chk("hold_len", 32'(cnt), 32'(HOLD + 1));
    chk("gap_gnt",  32'(gnt), 32'h0);
    tick();
`ifdef SSEG_ARB_FIXED_PRIO_EN
    nxt = 1;
`else
    nxt = 2;
`endif
    chk("rot_gnt", 32'(gnt), 32'(nxt));

    // both held: each tenure lasts HOLD+1 cycles
    cnt = 0;
    while (gnt == 2'(nxt) && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("hold_len2", 32'(cnt), 32'(HOLD + 1));
    chk("gap_gnt2",  32'(gnt), 32'h0);
    tick();
    chk("rot_gnt2",  32'(gnt), 32'h1);

    // owner drops on its 3rd owned cycle with nobody else waiting
    req = 2'b00;
    repeat (4) tick();
    req = 2'b01;
    repeat (3) tick();
    req = 2'b00;
    tick();
    chk("drop_gnt",  32'(gnt),  32'h0);
    chk("drop_busy", 32'(busy), 32'h1);
    tick();
    chk("drop_idle", 32'(busy), 32'h0);
    chk("drop_an",   32'(an),   32'hF);

    // asynchronous reset in the middle of requester 1's tenure
    req = 2'b10;
    repeat (5) tick();
    chk("pre_rst_gnt", 32'(gnt), 32'h2);
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_gnt",  32'(gnt),  32'h0);
    chk("async_busy", 32'(busy), 32'h0);
    chk("async_an",   32'(an),   32'hF);
    chk("async_sseg", 32'(sseg), 32'hFF);
    req = 2'b11;
    tick();
    #2 reset_n = 1'b1;
    tick();
    chk("post_rst_gnt", 32'(gnt), 32'h1);

    // random requests and live frame changes
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) req = N'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) frame = {$urandom, $urandom};
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
